// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM timebase and comparator blocks.
package pwm_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_PSC_WIDTH = 8;

    // Output alignment codes interpreted by pwm_gen
    localparam logic [1:0] FUNCTION_ALIGN_LEFT    = 2'b00;
    localparam logic [1:0] FUNCTION_ALIGN_RIGHT   = 2'b01;
    localparam logic [1:0] FUNCTION_RANGE_BETWEEN = 2'b10;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider for the PWM timebase: one-cycle tick every prescale_a+1 enabled clocks.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PSC_WIDTH = DEF_PSC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clear,
    input  logic [PSC_WIDTH-1:0] prescale_a,
    output logic                 tick
);

    logic [PSC_WIDTH-1:0] cnt;

    // >= rather than == so a count left above a smaller reloaded prescale_a
    // still terminates instead of running through the full range.
    assign tick = en && !clear && (cnt >= prescale_a);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + PSC_WIDTH'(1);
        end
    end

endmodule

// File: rtl/pwm_counter.sv
// PWM timebase: double-buffered period/prescale/direction, up or down count, period_end pulse.
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int PSC_WIDTH = DEF_PSC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 count_reset,
    input  logic [WIDTH-1:0]     period,
    input  logic [PSC_WIDTH-1:0] prescale,
    input  logic                 upnotdown,
    output logic [WIDTH-1:0]     count_val,
    output logic                 period_end
);

    logic [WIDTH-1:0]     period_a;
    logic [PSC_WIDTH-1:0] prescale_a;
    logic                 dir_a;
    logic                 tick;
    logic                 wrap;
    logic                 shadow_load;
    logic                 degenerate;
    logic [WIDTH-1:0]     last_a;
    logic [WIDTH-1:0]     start_val;

    pwm_prescaler #(.PSC_WIDTH(PSC_WIDTH)) u_psc (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clear      (count_reset),
        .prescale_a (prescale_a),
        .tick       (tick)
    );

    assign degenerate = (period_a <= WIDTH'(1));
    assign last_a     = degenerate ? '0 : period_a - WIDTH'(1);

    // First value of a period comes from the inputs, since the shadows load
    // on the same edge; restart and wrap share it.
    always_comb begin
        start_val = '0;
        if (upnotdown == DIR_DOWN && period > WIDTH'(1))
            start_val = period - WIDTH'(1);
    end

    always_comb begin
        wrap = 1'b1;
        if (!degenerate) begin
            if (dir_a == DIR_UP)
                wrap = (count_val >= last_a);
            else
                wrap = (count_val == '0) || (count_val > last_a);
        end
    end

    assign shadow_load = !en || count_reset || (tick && wrap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_a   <= '0;
            prescale_a <= '0;
            dir_a      <= DIR_UP;
        end else if (shadow_load) begin
            period_a   <= period;
            prescale_a <= prescale;
            dir_a      <= upnotdown;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_val  <= '0;
            period_end <= 1'b0;
        end else if (count_reset) begin
            count_val  <= start_val;
            period_end <= 1'b1;
        end else if (tick) begin
            period_end <= wrap;
            if (wrap)
                count_val <= start_val;
            else if (dir_a == DIR_UP)
                count_val <= count_val + WIDTH'(1);
            else
                count_val <= count_val - WIDTH'(1);
        end else begin
            period_end <= 1'b0;
        end
    end

endmodule

// File: doc/pwm_counter.md
# pwm_counter

Timebase counter that feeds `pwm_gen`: produces the `count_val` sequence that the PWM comparator stage compares against `compare1`/`compare2`. It supports a programmable prescaler and up or down counting over a programmable period. Period, prescale and direction are double-buffered, so register writes take effect only at a period boundary and never cause a mid-period glitch on `pwm_out`.

## Interface
- `WIDTH`, 16: counter, period and `count_val` width.
- `PSC_WIDTH`, 8: prescaler width.

- `clk`  in  1  peripheral clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable (same source as `pwm_en`).
- `count_reset`  in  1  synchronous restart pulse, one cycle.
- `period`  in  WIDTH  requested period in ticks; count range is 0..period-1.
- `prescale`  in  PSC_WIDTH  tick every `prescale`+1 clocks.
- `upnotdown`  in  1  1 = count up, 0 = count down.
- `count_val`  out  WIDTH  registered counter value, to `pwm_gen`.
- `period_end`  out  1  one-cycle pulse when `count_val` takes the first value of a new period.

## Operation
- **Reset values:**
  - `count_val` = 0, `period_end` = 0.
  - Prescaler count = 0.
  - Shadow `period_a` = 0, `prescale_a` = 0, `dir_a` = 1.
- **Shadow load:**
  - `period_a`, `prescale_a` and `dir_a` are loaded from the inputs on every clock while `en` = 0 (transparent).
  - Otherwise they load only on a wrap tick or on `count_reset`.
- **Prescaler:**
  - While `en` = 1, the prescaler counts 0..`prescale_a`.
  - A tick is issued when the prescaler count equals `prescale_a`; the prescaler count then returns to 0.
  - `prescale_a` = 0 gives a tick every clock.
- **Up count, on tick:**
  - If `count_val` ≥ `period_a`-1, `count_val` wraps to 0 and this is a wrap.
  - Otherwise `count_val` increments by 1.
- **Down count, on tick:**
  - If `count_val` = 0 or `count_val` > `period_a`-1, `count_val` loads `period_a`-1 and this is a wrap.
  - Otherwise `count_val` decrements by 1.
- **Degenerate period:** `period_a` ≤ 1 holds `count_val` at 0, and every tick is a wrap.
- **Wrap values:** the value loaded on a wrap uses the newly loaded shadow values (the new period and direction apply from the first count of the new period).
- **`count_reset`** has the highest priority and acts regardless of `en`:
  - Prescaler count is set to 0 and all shadows load from the inputs.
  - `count_val` becomes 0 if `upnotdown` = 1, else max(`period`,1)-1.
  - `period_end` pulses.
- **`en` = 0:** `count_val` and the prescaler count hold; `period_end` = 0.
- **Width rule:** `period_a`-1 is computed at WIDTH bits with `period_a` = 0 treated as degenerate. No arithmetic wraps through the all-ones value.

## Timing
- `count_val` and `period_end` are registered outputs with no combinational path from inputs.
- **Tick latency:** a tick decided at edge N updates `count_val` after edge N. `period_end` is high for exactly the cycle after that edge.
- **Restart latency:** `count_reset` sampled high at edge N gives the restart value on `count_val` after edge N and the prescaler restarts from 0. The first increment occurs `prescale`+1 clocks later.
- **`en` rising:** with the prescaler at 0, the first tick occurs on the (`prescale_a`+1)-th enabled edge.
- **Write timing:** an input write landing in the same cycle as a wrap tick is captured by that wrap.
- **Reset mid-operation:** `rst_n` low forces all reset values immediately (asynchronously); counting resumes from 0 on the first edge after release with `en` = 1.

## Structure
- **Shared package `pwm_pkg`:**
  - `DIR_UP` = 1'b1, `DIR_DOWN` = 1'b0.
  - Default `WIDTH`/`PSC_WIDTH`.
  - The `FUNCTION_*` alignment codes also used by `pwm_gen`.
- **Sub-module `pwm_prescaler`:**
  - Inputs: `clk`, `rst_n`, enable, clear, `prescale_a`.
  - Output: single-cycle `tick`.
- **Top level** holds the shadow registers, the counter and `period_end` generation.

## Test plan
- **Basic up count:** `period`=5, `prescale`=0, `upnotdown`=1, `en`=1 → `count_val` 0,1,2,3,4,0,… every clock; `period_end` high each time 0 appears.
- **Prescaled down count:** `period`=4, `prescale`=2, `upnotdown`=0 → `count_val` 3,2,1,0,3, each held 3 clocks; `period_end` accompanies every return to 3.
- **Shadowed period write:** while running `period`=10 with `count_val`=6, write `period`=4 → `count_val` continues 7,8,9, then 0,1,2,3,0.
- **Restart mid-period:** `count_reset` pulse at `count_val`=3 (up, `prescale`=1) → `count_val`=0 next cycle, `period_end`=1, next increment 2 clocks later.
- **Degenerate periods and halt:** `period`=0 or 1 → `count_val` stays 0, `period_end` every tick. `en`=0 for 5 clocks at `count_val`=7 → holds 7, no `period_end`.
- **Async reset:** `rst_n` low mid-count at `count_val`=9 → `count_val`=0 and `period_end`=0 immediately; after release, counting restarts from 0.
